fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter and the IF/ID pipeline register. Consumes the hazard unit's `pcwrite` / `IFIDwrite` stall controls and the ID-stage branch decision. Feeds ID with the fetched instruction and PC+4. Also keeps saturating stall and flush counters for performance debug.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset.
- `NOP_INST`, 32'h0000_0000: instruction word inserted into IF/ID on flush and at reset.
- `CNT_W`, 16: width of the performance counters.

Reset is asynchronous and active-low; this is already decided. There is one clock.

- `clk_i`  in  1  pipeline clock.
- `rst_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  leaves IDLE; level-sampled.
- `pcwrite_i`  in  1  1 = PC may advance (from hazard detection).
- `ifidwrite_i`  in  1  1 = IF/ID may load (from hazard detection).
- `branch_taken_i`  in  1  ID-stage branch resolved taken.
- `branch_target_i`  in  32  branch target address; bits [1:0] are ignored.
- `imem_addr_o`  out  32  instruction memory address; always equals `pc_o`.
- `imem_data_i`  in  32  instruction word, combinational read of `imem_addr_o`.
- `pc_o`  out  32  current PC.
- `ifid_inst_o`  out  32  IF/ID instruction.
- `ifid_pc4_o`  out  32  IF/ID PC+4.
- `ifid_valid_o`  out  1  0 = IF/ID holds an inserted bubble.
- `stall_cnt_o`  out  CNT_W  count of RUN cycles with `pcwrite_i` = 0.
- `flush_cnt_o`  out  CNT_W  count of applied flushes.

## Operation
- FSM states: IDLE and RUN.
  - Reset enters IDLE.
  - IDLE moves to RUN on the first clock edge with `start_i` = 1.
  - RUN is left only by reset.
- In IDLE:
  - PC holds.
  - IF/ID holds `NOP_INST` with valid = 0.
  - Counters hold.
- In RUN, the next PC is chosen in this priority:
  - `pcwrite_i` = 0: hold. A stall overrides the branch, because the ID branch decision is stale while a load-use stall is active.
  - else if `branch_taken_i` = 1: load `{branch_target_i[31:2], 2'b00}`.
  - else: PC + 4, modulo 2^32. Wrap from 0xFFFF_FFFC to 0 is silent.
- In RUN, IF/ID is updated independently of the PC path:
  - `ifidwrite_i` = 0: hold all IF/ID fields.
  - else if `branch_taken_i` = 1 and `pcwrite_i` = 1: flush. Load `NOP_INST`, pc4 = 0, valid = 0.
  - else: load `imem_data_i`, PC + 4, valid = 1.
- Counters:
  - `stall_cnt_o` increments in RUN when `pcwrite_i` = 0.
  - `flush_cnt_o` increments when a flush is applied.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation returns every register to its reset value immediately, without waiting for a clock edge.

## Timing
- Reset values:
  - `pc_o` = `RESET_PC`.
  - `ifid_inst_o` = `NOP_INST`, `ifid_pc4_o` = 0, `ifid_valid_o` = 0.
  - Both counters = 0.
  - FSM = IDLE.
- `start_i` sampled high at edge N: RUN from N. The first PC increment and the first IF/ID load happen at edge N+1.
- `imem_addr_o` is combinational from the PC register. Fetch latency: an instruction at PC p appears on `ifid_inst_o` one edge after `pc_o` = p, provided IF/ID loads.
- Taken branch at edge N:
  - `pc_o` = target after N.
  - The wrong-path instruction is replaced by a bubble.
  - The target instruction is in IF/ID after N+1.
- Stall: while `pcwrite_i` = 0 and `ifidwrite_i` = 0, outputs are frozen cycle-for-cycle.
- All outputs are registered except `imem_addr_o`, which is a wire copy of `pc_o`.

## Structure
- Shared pipeline package holds:
  - the state type {IDLE, RUN};
  - the `NOP_INST` default;
  - the instruction-width constant (32).
- Natural sub-module: `sat_counter` (parameterised width, async active-low reset, enable input, saturating). It is instantiated twice, for stalls and for flushes.
- PC, IF/ID register and FSM stay in `fetch_stage`.

## Test plan
- Reset then `start_i` pulse, imem returns 0x2010_0001 at PC 0 -> after edge N+1: `pc_o` = 4, `ifid_inst_o` = 0x2010_0001, `ifid_pc4_o` = 4, valid = 1.
- Load-use stall for 2 cycles (`pcwrite_i` = `ifidwrite_i` = 0) at PC 0x10 -> PC stays 0x10, IF/ID frozen, `stall_cnt_o` = 2.
- `branch_taken_i` = 1 with target 0x0000_0043 at PC 0x20 -> `pc_o` = 0x40, IF/ID = NOP with valid 0, `flush_cnt_o` = 1; next edge IF/ID holds the instruction at 0x40.
- `branch_taken_i` = 1 together with `pcwrite_i` = `ifidwrite_i` = 0 -> no redirect, no flush, `flush_cnt_o` unchanged, `stall_cnt_o` + 1.
- PC at 0xFFFF_FFFC advancing -> `pc_o` = 0, `ifid_pc4_o` = 0. Also with CNT_W = 4 and 20 stall cycles -> `stall_cnt_o` = 0xF.
- `rst_i` asserted between edges mid-run -> all outputs at reset values before the next edge, FSM in IDLE, `start_i` required again.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its helpers.
package fetch_stage_pkg;

    localparam int INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : fetch_stage_pkg

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: advance only when enabled and not already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with asynchronous active-low clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register,
// IDLE/RUN control and saturating stall/flush performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF,
    parameter int                CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              pcwrite_i,
    input  logic              ifidwrite_i,
    input  logic              branch_taken_i,
    input  logic [INST_W-1:0] branch_target_i,
    output logic [INST_W-1:0] imem_addr_o,
    input  logic [INST_W-1:0] imem_data_i,
    output logic [INST_W-1:0] pc_o,
    output logic [INST_W-1:0] ifid_inst_o,
    output logic [INST_W-1:0] ifid_pc4_o,
    output logic              ifid_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    state_e            state_q, state_d;
    logic [INST_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
    logic [INST_W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [INST_W-1:0] pc_plus4;
    logic              stall_en;
    logic              flush_en;

    // Sequential PC increment; wrap past 0xFFFF_FFFC is intentionally silent.
    assign pc_plus4 = pc_q + 32'd4;

    // Next-state logic for FSM, PC and IF/ID; a stall outranks a branch
    // because the ID branch decision is stale during a load-use stall.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        stall_en     = 1'b0;
        flush_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!pcwrite_i) begin
                    stall_en = 1'b1;
                end else if (branch_taken_i) begin
                    pc_d = branch_target_i & 32'hFFFF_FFFC;
                end else begin
                    pc_d = pc_plus4;
                end

                if (ifidwrite_i) begin
                    if (branch_taken_i && pcwrite_i) begin
                        ifid_inst_d  = NOP_INST;
                        ifid_pc4_d   = '0;
                        ifid_valid_d = 1'b0;
                        flush_en     = 1'b1;
                    end else begin
                        ifid_inst_d  = imem_data_i;
                        ifid_pc4_d   = pc_plus4;
                        ifid_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC and IF/ID registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ifid_inst_q  <= NOP_INST;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_en),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (flush_en),
        .cnt_o (flush_cnt_o)
    );

    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ifid_inst_o  = ifid_inst_q;
    assign ifid_pc4_o   = ifid_pc4_q;
    assign ifid_valid_o = ifid_valid_q;

endmodule : fetch_stage
